// File: rtl/image_stream_loader_pkg.sv
// Shared widths, FSM states and helpers for the image stream loader.
package image_stream_loader_pkg;

    localparam int PCIE_DATA_WIDTH = 16;
    localparam int BUF_ADDR_WIDTH  = 18;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } load_state_t;

    function automatic int plane_words(input int w, input int h);
        return w * h;
    endfunction

endpackage

// File: rtl/image_stream_loader_if.sv
// Host stream in, feature-map buffer write port out.
interface image_stream_loader_if
    import image_stream_loader_pkg::*;
#(
    parameter int DATA_WIDTH = PCIE_DATA_WIDTH,
    parameter int ADDR_WIDTH = BUF_ADDR_WIDTH
);

    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;

    modport master (
        output in_data, in_valid, wr_ready,
        input  in_ready, wr_valid, wr_addr, wr_data
    );

    modport slave (
        input  in_data, in_valid, wr_ready,
        output in_ready, wr_valid, wr_addr, wr_data
    );

endinterface

// File: rtl/image_stream_loader_addr_gen.sv
// x/y/c walk over the frame with multiplier-free planar address.
module image_stream_loader_addr_gen
    import image_stream_loader_pkg::*;
#(
    parameter int IMG_W       = 227,
    parameter int IMG_H       = 227,
    parameter int CHANNELS    = 3,
    parameter int ADDR_WIDTH  = BUF_ADDR_WIDTH,
    parameter int INTERLEAVED = 0
) (
    input  logic                  clk,
    input  logic                  clear,
    input  logic                  advance,
    output logic [ADDR_WIDTH-1:0] addr,
    output logic                  last
);

    localparam logic [ADDR_WIDTH-1:0] X_MAX = ADDR_WIDTH'(IMG_W - 1);
    localparam logic [ADDR_WIDTH-1:0] Y_MAX = ADDR_WIDTH'(IMG_H - 1);
    localparam logic [ADDR_WIDTH-1:0] C_MAX = ADDR_WIDTH'(CHANNELS - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW   = ADDR_WIDTH'(IMG_W);
    localparam logic [ADDR_WIDTH-1:0] PLANE =
        ADDR_WIDTH'(plane_words(IMG_W, IMG_H));
    localparam logic [ADDR_WIDTH-1:0] ONE   = ADDR_WIDTH'(1);

    logic [ADDR_WIDTH-1:0] x;
    logic [ADDR_WIDTH-1:0] y;
    logic [ADDR_WIDTH-1:0] c;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] plane_base;
    logic                  x_wrap;
    logic                  y_wrap;
    logic                  c_wrap;
    logic                  step_x;
    logic                  step_y;
    logic                  step_c;

    assign x_wrap = (x == X_MAX);
    assign y_wrap = (y == Y_MAX);
    assign c_wrap = (c == C_MAX);
    assign last   = x_wrap && y_wrap && c_wrap;
    assign addr   = plane_base + row_base + x;

    // plane_base tracks c*PLANE in both orders, so no offset table is needed
    always_comb begin
        step_x = 1'b1;
        step_y = x_wrap;
        step_c = x_wrap && y_wrap;
        if (INTERLEAVED != 0) begin
            step_c = 1'b1;
            step_x = c_wrap;
            step_y = c_wrap && x_wrap;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            x          <= '0;
            y          <= '0;
            c          <= '0;
            row_base   <= '0;
            plane_base <= '0;
        end else if (advance) begin
            if (step_x) begin
                x <= x_wrap ? '0 : x + ONE;
            end
            if (step_y) begin
                y        <= y_wrap ? '0 : y + ONE;
                row_base <= y_wrap ? '0 : row_base + ROW;
            end
            if (step_c) begin
                c          <= c_wrap ? '0 : c + ONE;
                plane_base <= c_wrap ? '0 : plane_base + PLANE;
            end
        end
    end

endmodule

// File: rtl/image_stream_loader.sv
// Frame loader: host words in, planar buffer writes out, done per frame.
module image_stream_loader
    import image_stream_loader_pkg::*;
#(
    parameter int DATA_WIDTH  = PCIE_DATA_WIDTH,
    parameter int IMG_W       = 227,
    parameter int IMG_H       = 227,
    parameter int CHANNELS    = 3,
    parameter int ADDR_WIDTH  = BUF_ADDR_WIDTH,
    parameter int INTERLEAVED = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    image_stream_loader_if.slave  bus,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] word_count
);

    load_state_t           state;
    logic                  wr_valid_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic                  in_ready;
    logic                  accept;
    logic                  start_fire;
    logic [ADDR_WIDTH-1:0] gen_addr;
    logic                  gen_last;

    assign start_fire = (state == ST_IDLE) && start;
    // ready depends only on the output register, never on in_valid
    assign in_ready   = (state == ST_LOAD) && (!wr_valid_q || bus.wr_ready);
    assign accept     = in_ready && bus.in_valid;

    assign bus.in_ready = in_ready;
    assign bus.wr_valid = wr_valid_q;
    assign bus.wr_addr  = wr_addr_q;
    assign bus.wr_data  = wr_data_q;

    image_stream_loader_addr_gen #(
        .IMG_W       (IMG_W),
        .IMG_H       (IMG_H),
        .CHANNELS    (CHANNELS),
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INTERLEAVED (INTERLEAVED)
    ) u_addr_gen (
        .clk     (clk),
        .clear   (rst || start_fire),
        .advance (accept),
        .addr    (gen_addr),
        .last    (gen_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            word_count <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_LOAD;
                        busy       <= 1'b1;
                        word_count <= '0;
                    end
                end
                ST_LOAD: begin
                    if (accept) begin
                        wr_valid_q <= 1'b1;
                        wr_addr_q  <= gen_addr;
                        wr_data_q  <= bus.in_data;
                        word_count <= word_count + ADDR_WIDTH'(1);
                        if (gen_last) begin
                            state <= ST_DRAIN;
                        end
                    end else if (bus.wr_ready) begin
                        wr_valid_q <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (bus.wr_ready) begin
                        wr_valid_q <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_image_stream_loader.sv
// Planar and interleaved 4x3x2 loaders driven side by side, scoreboarded.
module tb_image_stream_loader;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int C  = 2;
    localparam int N  = W * H * C;
    localparam int DW = 16;
    localparam int AW = 18;

    typedef logic [AW+DW-1:0] ent_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic          wr_ready;
    logic [DW-1:0] din;
    logic          busy_p;
    logic          done_p;
    logic          busy_i;
    logic          done_i;
    logic [AW-1:0] wc_p;
    logic [AW-1:0] wc_i;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   np;
    int   ni;
    int   dn_p;
    int   dn_i;
    int   done_cyc_p;
    int   last_hs_p;
    bit   acc;
    ent_t qp[$];
    ent_t qi[$];

    image_stream_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifp ();
    image_stream_loader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) ifi ();

    assign ifp.in_data  = din;
    assign ifp.in_valid = in_valid;
    assign ifp.wr_ready = wr_ready;
    assign ifi.in_data  = din;
    assign ifi.in_valid = in_valid;
    assign ifi.wr_ready = wr_ready;

    image_stream_loader #(
        .DATA_WIDTH (DW), .IMG_W (W), .IMG_H (H),
        .CHANNELS (C), .ADDR_WIDTH (AW), .INTERLEAVED (0)
    ) u_p (
        .clk (clk), .rst (rst), .start (start), .bus (ifp),
        .busy (busy_p), .done (done_p), .word_count (wc_p)
    );

    image_stream_loader #(
        .DATA_WIDTH (DW), .IMG_W (W), .IMG_H (H),
        .CHANNELS (C), .ADDR_WIDTH (AW), .INTERLEAVED (1)
    ) u_i (
        .clk (clk), .rst (rst), .start (start), .bus (ifi),
        .busy (busy_i), .done (done_i), .word_count (wc_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Planar index n; interleaved n = pixel*C + c with pixel = y*W + x
    function automatic logic [AW-1:0] exp_addr(input bit il, input int n);
        if (!il) return AW'(n);
        return AW'((n % C) * W * H + n / C);
    endfunction

    task automatic sample();
        ent_t e;
        if (rst) return;
        if (ifp.in_valid && ifp.in_ready) begin
            qp.push_back({exp_addr(1'b0, np), ifp.in_data});
            np++;
            acc = 1'b1;
        end
        if (ifi.in_valid && ifi.in_ready) begin
            qi.push_back({exp_addr(1'b1, ni), ifi.in_data});
            ni++;
        end
        if (ifp.wr_valid && ifp.wr_ready) begin
            last_hs_p = cyc;
            chk("p_sb_nonempty", 64'(qp.size() != 0), 64'd1);
            if (qp.size() != 0) begin
                e = qp.pop_front();
                chk("p_wr", 64'({ifp.wr_addr, ifp.wr_data}), 64'(e));
            end
        end
        if (ifi.wr_valid && ifi.wr_ready) begin
            chk("i_sb_nonempty", 64'(qi.size() != 0), 64'd1);
            if (qi.size() != 0) begin
                e = qi.pop_front();
                chk("i_wr", 64'({ifi.wr_addr, ifi.wr_data}), 64'(e));
            end
        end
        if (done_p) begin
            dn_p++;
            done_cyc_p = cyc;
        end
        if (done_i) dn_i++;
    endtask

    task automatic tick(input logic v, input logic wr, input logic st,
                        input logic r = 1'b0);
        @(negedge clk);
        if (acc) din = din + 16'd1;
        acc      = 1'b0;
        in_valid = v;
        wr_ready = wr;
        start    = st;
        rst      = r;
        cyc++;
        #1;
        sample();
    endtask

    task automatic check_idle(input string tag, input int wc);
        chk({tag, "_in_ready"}, 64'(ifp.in_ready), 64'd0);
        chk({tag, "_wr_valid"}, 64'(ifp.wr_valid), 64'd0);
        chk({tag, "_busy"}, 64'(busy_p), 64'd0);
        chk({tag, "_done"}, 64'(done_p), 64'd0);
        chk({tag, "_wc"}, 64'(wc_p), 64'(wc));
        chk({tag, "_i_busy"}, 64'(busy_i), 64'd0);
        chk({tag, "_i_wc"}, 64'(wc_i), 64'(wc));
    endtask

    task automatic run_frame(input int stall_at, input int abort_at,
                             input bit poke);
        int t0;
        int stall;
        logic [DW-1:0] base;
        np    = 0;
        ni    = 0;
        dn_p  = 0;
        dn_i  = 0;
        stall = 0;
        base  = din;
        tick(1'b1, 1'b1, 1'b1);
        t0 = cyc;
        for (int k = 0; k < 120 && dn_p == 0; k++) begin
            if (abort_at >= 0 && np == abort_at) begin
                tick(1'b1, 1'b1, 1'b0, 1'b1);
                qp.delete();
                qi.delete();
                np  = 0;
                ni  = 0;
                acc = 1'b0;
                tick(1'b1, 1'b1, 1'b0);
                check_idle("abort", 0);
                chk("abort_wr_addr", 64'(ifp.wr_addr), 64'd0);
                return;
            end
            if (stall_at >= 0 && np == stall_at + 1 && stall < 3) begin
                stall++;
                tick(1'b1, 1'b0, 1'b0);
                chk("stall_wr_valid", 64'(ifp.wr_valid), 64'd1);
                chk("stall_addr", 64'(ifp.wr_addr), 64'(stall_at));
                chk("stall_data", 64'(ifp.wr_data), 64'(base + DW'(stall_at)));
                chk("stall_in_ready", 64'(ifp.in_ready), 64'd0);
            end else begin
                tick(1'b1, 1'b1, poke && (k % 3 == 1));
            end
        end
        chk("p_done_cnt", 64'(dn_p), 64'd1);
        chk("i_done_cnt", 64'(dn_i), 64'd1);
        chk("p_frame_len", 64'(done_cyc_p - t0),
            64'(stall_at >= 0 ? 29 : 26));
        chk("p_done_lat", 64'(done_cyc_p), 64'(last_hs_p + 1));
        chk("p_words", 64'(wc_p), 64'(N));
        chk("i_words", 64'(wc_i), 64'(N));
        chk("p_busy_at_done", 64'(busy_p), 64'd0);
        chk("p_sb_empty", 64'(qp.size()), 64'd0);
        chk("i_sb_empty", 64'(qi.size()), 64'd0);
        chk("p_pushed", 64'(np), 64'(N));
        tick(1'b0, 1'b1, 1'b0);
        chk("p_done_pulse", 64'(done_p), 64'd0);
        chk("p_idle_busy", 64'(busy_p), 64'd0);
    endtask

    initial begin
        np = 0; ni = 0; dn_p = 0; dn_i = 0;
        done_cyc_p = 0; last_hs_p = 0; acc = 1'b0;
        din = 16'h1000;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;

        tick(1'b0, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 1'b1, 1'b1, 1'b1);
        tick(1'b1, 1'b1, 1'b0);
        check_idle("reset", 0);
        chk("reset_wr_addr", 64'(ifp.wr_addr), 64'd0);
        chk("reset_wr_data", 64'(ifp.wr_data), 64'd0);

        // in_valid while idle must be dropped
        repeat (3) tick(1'b1, 1'b1, 1'b0);
        chk("idle_no_accept", 64'(np), 64'd0);
        check_idle("idle", 0);

        run_frame(-1, -1, 1'b0);
        repeat (2) tick(1'b1, 1'b1, 1'b0);
        check_idle("hold", N);

        din = 16'h2000;
        run_frame(5, -1, 1'b0);

        din = 16'h3000;
        run_frame(-1, 10, 1'b0);
        dn_p = 0;
        repeat (4) tick(1'b0, 1'b1, 1'b0);
        chk("abort_no_done", 64'(dn_p), 64'd0);
        run_frame(-1, -1, 1'b0);

        din = 16'h4000;
        run_frame(-1, -1, 1'b1);
        run_frame(-1, -1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
